// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: RDY after WIDTH+1 edges (WIDTH/2+1 for multiply with MULTDIV_BOOTH_EN),
// divide-by-zero after 1 edge; busy stalls the pipeline, and a new start while busy aborts the current op.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic                r_neg;
  logic                r_divz;
  logic [2*WIDTH-1:0]  r_prod;
  logic [2*WIDTH-1:0]  r_mcand;
  logic [WIDTH:0]      r_mplier;
  logic [WIDTH-1:0]    r_rem;
  logic [WIDTH-1:0]    r_quo;
  logic [WIDTH-1:0]    r_dvsr;
  logic [WIDTH-1:0]    r_result;
  logic                r_exc;
  logic                r_rdy;

  logic                w_start;
  logic                w_last;
  logic [WIDTH-1:0]    w_absA;
  logic [WIDTH-1:0]    w_absB;
  logic                w_divz_in;
  logic [2*WIDTH-1:0]  w_madd;
  logic [2*WIDTH-1:0]  w_sprod;
  logic                w_mexc;
  logic [WIDTH:0]      w_shift;
  logic [WIDTH:0]      w_trial;
  logic [WIDTH-1:0]    w_quot;
  logic                w_dexc;

  assign w_start   = ctrl_MULT | ctrl_DIV;
  assign w_last    = (r_cnt == '0);
  assign w_absA    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_absB    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign w_divz_in = (data_operandB == '0);

`ifdef MULTDIV_BOOTH_EN
  // Booth works on the signed operands directly, so the accumulator is already the signed product.
  always_comb begin
    w_madd = '0;
    case (r_mplier[2:0])
      3'b001, 3'b010: w_madd = r_mcand;
      3'b011:         w_madd = r_mcand << 1;
      3'b100:         w_madd = -(r_mcand << 1);
      3'b101, 3'b110: w_madd = -r_mcand;
      default:        w_madd = '0;
    endcase
  end
  assign w_sprod = r_prod;
`else
  assign w_madd  = r_mplier[0] ? r_mcand : '0;
  assign w_sprod = r_neg ? -r_prod : r_prod;
`endif

  // Product fits in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign extension.
  assign w_mexc = ~((&w_sprod[2*WIDTH-1:WIDTH-1]) | ~(|w_sprod[2*WIDTH-1:WIDTH-1]));

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvsr};
  assign w_quot  = r_neg ? -r_quo : r_quo;
  // A positive quotient with the top bit set is only reachable as most-negative / -1.
  assign w_dexc  = r_divz | (~r_neg & r_quo[WIDTH-1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = IDLE;
      MUL:     if (w_last) w_next = DONE;
      DIV:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (ctrl_MULT)     w_next = MUL;
    else if (ctrl_DIV) w_next = DIV;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_divz   <= 1'b0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        if (ctrl_MULT) begin
          r_divz <= 1'b0;
          r_prod <= '0;
`ifdef MULTDIV_BOOTH_EN
          r_mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
          r_mplier <= {data_operandB, 1'b0};
          r_cnt    <= CW'(WIDTH / 2);
`else
          r_mcand  <= {{WIDTH{1'b0}}, w_absA};
          r_mplier <= {1'b0, w_absB};
          r_cnt    <= CW'(WIDTH);
`endif
        end else begin
          r_divz <= w_divz_in;
          r_rem  <= '0;
          r_quo  <= w_absA;
          r_dvsr <= w_absB;
          r_cnt  <= w_divz_in ? '0 : CW'(WIDTH);
        end
      end else begin
        case (r_state)
          MUL: begin
            if (w_last) begin
              r_result <= w_sprod[WIDTH-1:0];
              r_exc    <= w_mexc;
              r_rdy    <= 1'b1;
            end else begin
              r_prod <= r_prod + w_madd;
              r_cnt  <= r_cnt - 1'b1;
`ifdef MULTDIV_BOOTH_EN
              r_mcand  <= r_mcand << 2;
              r_mplier <= {{2{r_mplier[WIDTH]}}, r_mplier[WIDTH:2]};
`else
              r_mcand  <= r_mcand << 1;
              r_mplier <= r_mplier >> 1;
`endif
            end
          end
          DIV: begin
            if (w_last) begin
              r_result <= r_divz ? '0 : w_quot;
              r_exc    <= w_dexc;
              r_rdy    <= 1'b1;
            end else begin
              r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state == MUL) || (r_state == DIV);

endmodule
